// File: rtl/carpma_siralayici.sv
// rtl/carpma_siralayici.sv - shared shift-add multiplier sequencer for KAREAL.TOPLA and CARP.CIKAR
module carpma_siralayici #(
    parameter int GENISLIK = 32
) (
    input  logic                saat,
    input  logic                reset,
    input  logic                istek_gecerli,
    output logic                istek_hazir,
    input  logic                islem,
    input  logic [4:0]          rd_adres,
    input  logic [GENISLIK-1:0] a,
    input  logic [GENISLIK-1:0] b,
    output logic                sonuc_gecerli,
    input  logic                sonuc_hazir,
    output logic [GENISLIK-1:0] sonuc,
    output logic [4:0]          sonuc_rd,
    output logic                mesgul
);

    localparam int SAYAC_W = $clog2(GENISLIK + 1);

    typedef enum logic [2:0] {
        BOS       = 3'd0,
        CARP1     = 3'd1,
        CARP2     = 3'd2,
        BIRLESTIR = 3'd3,
        SONUC     = 3'd4
    } durum_t;

    durum_t              state_q, state_d;
    logic [GENISLIK-1:0] a_q, a_d;
    logic [GENISLIK-1:0] b_q, b_d;
    logic                islem_q, islem_d;
    logic [4:0]          rd_q, rd_d;
    logic [GENISLIK-1:0] mcand_q, mcand_d;
    logic [GENISLIK-1:0] mplier_q, mplier_d;
    logic [GENISLIK-1:0] acc_q, acc_d;
    logic [SAYAC_W-1:0]  sayac_q, sayac_d;
    logic [GENISLIK-1:0] ara_q, ara_d;
    logic [GENISLIK-1:0] sonuc_q, sonuc_d;
    logic [4:0]          sonuc_rd_q, sonuc_rd_d;
    logic [GENISLIK-1:0] acc_step;
    logic                son_adim;

    // Accumulator value after the current step; on the last step this is the full product.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign son_adim = (sayac_q == SAYAC_W'(GENISLIK - 1));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        islem_d    = islem_q;
        rd_d       = rd_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        sayac_d    = sayac_q;
        ara_d      = ara_q;
        sonuc_d    = sonuc_q;
        sonuc_rd_d = sonuc_rd_q;

        case (state_q)
            BOS: begin
                if (istek_gecerli) begin
                    a_d      = a;
                    b_d      = b;
                    islem_d  = islem;
                    rd_d     = rd_adres;
                    mcand_d  = a;
                    mplier_d = islem ? b : a;
                    acc_d    = '0;
                    sayac_d  = '0;
                    state_d  = CARP1;
                end
            end
            CARP1, CARP2: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                sayac_d  = sayac_q + SAYAC_W'(1);
                if (son_adim) begin
                    sayac_d = '0;
                    state_d = BIRLESTIR;
                    if (state_q == CARP1) begin
                        ara_d = acc_step;
                        if (!islem_q) begin
                            mcand_d  = b_q;
                            mplier_d = b_q;
                            acc_d    = '0;
                            state_d  = CARP2;
                        end
                    end
                end
            end
            BIRLESTIR: begin
                sonuc_d    = islem_q ? (ara_q - a_q) : (ara_q + acc_q);
                sonuc_rd_d = rd_q;
                state_d    = SONUC;
            end
            SONUC: begin
                if (sonuc_hazir) begin
                    state_d = BOS;
                end
            end
            default: state_d = BOS;
        endcase
    end

    always_ff @(posedge saat) begin
        if (!reset) begin
            state_q    <= BOS;
            a_q        <= '0;
            b_q        <= '0;
            islem_q    <= 1'b0;
            rd_q       <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            sayac_q    <= '0;
            ara_q      <= '0;
            sonuc_q    <= '0;
            sonuc_rd_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            islem_q    <= islem_d;
            rd_q       <= rd_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            sayac_q    <= sayac_d;
            ara_q      <= ara_d;
            sonuc_q    <= sonuc_d;
            sonuc_rd_q <= sonuc_rd_d;
        end
    end

    assign istek_hazir   = (state_q == BOS);
    assign mesgul        = (state_q != BOS);
    assign sonuc_gecerli = (state_q == SONUC);
    assign sonuc         = sonuc_q;
    assign sonuc_rd      = sonuc_rd_q;

endmodule

// File: tb/tb_carpma_siralayici.sv
// tb/tb_carpma_siralayici.sv - directed self-checking bench for carpma_siralayici
module tb_carpma_siralayici;

    logic        saat = 1'b0;
    logic        reset = 1'b0;
    logic        istek_gecerli = 1'b0;
    logic        istek_hazir;
    logic        islem = 1'b0;
    logic [4:0]  rd_adres = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sonuc_gecerli;
    logic        sonuc_hazir = 1'b0;
    logic [31:0] sonuc;
    logic [4:0]  sonuc_rd;
    logic        mesgul;

    int kontrol_sayisi = 0;
    int hata_sayisi = 0;

    carpma_siralayici #(.GENISLIK(32)) dut (
        .saat          (saat),
        .reset         (reset),
        .istek_gecerli (istek_gecerli),
        .istek_hazir   (istek_hazir),
        .islem         (islem),
        .rd_adres      (rd_adres),
        .a             (a),
        .b             (b),
        .sonuc_gecerli (sonuc_gecerli),
        .sonuc_hazir   (sonuc_hazir),
        .sonuc         (sonuc),
        .sonuc_rd      (sonuc_rd),
        .mesgul        (mesgul)
    );

    always #5 saat = ~saat;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic adim();
        @(posedge saat);
        #1;
    endtask

    // Presents a request and returns after the accept edge (+1).
    task automatic istek_ver(input logic op, input logic [4:0] rd, input logic [31:0] va, input logic [31:0] vb);
        int n;
        islem = op; rd_adres = rd; a = va; b = vb; istek_gecerli = 1'b1;
        n = 0;
        while (!istek_hazir && n < 200) begin
            adim();
            n++;
        end
        kontrol("istek_hazir_bekle", {31'd0, istek_hazir}, 32'd1);
        adim();
        istek_gecerli = 1'b0;
    endtask

    // Counts edges after accept until sonuc_gecerli; optionally scrambles inputs meanwhile.
    task automatic sonuc_bekle(input logic karistir, output int n);
        n = 0;
        do begin
            if (karistir) begin
                a = $urandom; b = $urandom; islem = 1'($urandom);
            end
            adim();
            n++;
        end while (!sonuc_gecerli && n < 200);
    endtask

    task automatic el_sikis();
        sonuc_hazir = 1'b1;
        adim();
        sonuc_hazir = 1'b0;
        kontrol("hs_gecerli_dustu", {31'd0, sonuc_gecerli}, 32'd0);
        kontrol("hs_istek_hazir", {31'd0, istek_hazir}, 32'd1);
    endtask

    task automatic calistir(input string etiket, input logic op, input logic [4:0] rd,
                            input logic [31:0] va, input logic [31:0] vb, input logic karistir,
                            input logic [31:0] beklenen, input int gecikme);
        int n;
        istek_ver(op, rd, va, vb);
        kontrol({etiket, "_mesgul"}, {31'd0, mesgul}, 32'd1);
        sonuc_bekle(karistir, n);
        kontrol({etiket, "_gecikme"}, n, gecikme);
        kontrol({etiket, "_sonuc"}, sonuc, beklenen);
        kontrol({etiket, "_rd"}, {27'd0, sonuc_rd}, {27'd0, rd});
        el_sikis();
    endtask

    initial begin
        int n;
        logic [31:0] tut_sonuc;
        logic [4:0]  tut_rd;

        reset = 1'b0;
        adim();
        adim();
        kontrol("rst_gecerli", {31'd0, sonuc_gecerli}, 32'd0);
        kontrol("rst_sonuc", sonuc, 32'd0);
        kontrol("rst_rd", {27'd0, sonuc_rd}, 32'd0);
        kontrol("rst_mesgul", {31'd0, mesgul}, 32'd0);
        kontrol("rst_ara", dut.ara_q, 32'd0);
        kontrol("rst_acc", dut.acc_q, 32'd0);
        reset = 1'b1;
        adim();
        kontrol("rst_istek_hazir", {31'd0, istek_hazir}, 32'd1);

        calistir("kt_3_4", 1'b0, 5'd5, 32'd3, 32'd4, 1'b0, 32'd25, 65);
        calistir("cc_7_5", 1'b1, 5'd9, 32'd7, 32'd5, 1'b0, 32'd28, 33);
        calistir("kt_wrap", 1'b0, 5'd1, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 65);
        calistir("cc_wrap", 1'b1, 5'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 33);

        // Backpressure with a competing request held high.
        istek_ver(1'b1, 5'd12, 32'd11, 32'd13);
        sonuc_bekle(1'b0, n);
        kontrol("bp_sonuc", sonuc, 32'd132);
        tut_sonuc = sonuc;
        tut_rd = sonuc_rd;
        islem = 1'b1; rd_adres = 5'd3; a = 32'd10; b = 32'd10; istek_gecerli = 1'b1;
        for (int i = 0; i < 10; i++) begin
            adim();
            kontrol("bp_sabit_sonuc", sonuc, tut_sonuc);
            kontrol("bp_sabit_rd", {27'd0, sonuc_rd}, {27'd0, tut_rd});
            kontrol("bp_kabul_yok", {31'd0, istek_hazir}, 32'd0);
        end
        kontrol("bp_rd", {27'd0, tut_rd}, 32'd12);
        el_sikis();
        adim();
        istek_gecerli = 1'b0;
        kontrol("bp_kabul", {31'd0, mesgul}, 32'd1);
        sonuc_bekle(1'b0, n);
        kontrol("bp2_gecikme", n, 33);
        kontrol("bp2_sonuc", sonuc, 32'd90);
        kontrol("bp2_rd", {27'd0, sonuc_rd}, 32'd3);
        el_sikis();

        // Abort on the 20th CARP1 cycle.
        istek_ver(1'b1, 5'd7, 32'd100, 32'd200);
        for (int i = 0; i < 19; i++) adim();
        reset = 1'b0;
        adim();
        kontrol("mr_gecerli", {31'd0, sonuc_gecerli}, 32'd0);
        kontrol("mr_sonuc", sonuc, 32'd0);
        kontrol("mr_rd", {27'd0, sonuc_rd}, 32'd0);
        kontrol("mr_mesgul", {31'd0, mesgul}, 32'd0);
        kontrol("mr_acc", dut.acc_q, 32'd0);
        kontrol("mr_sayac", 32'(dut.sayac_q), 32'd0);
        reset = 1'b1;
        adim();
        kontrol("mr_istek_hazir", {31'd0, istek_hazir}, 32'd1);
        calistir("mr_cc_2_3", 1'b1, 5'd4, 32'd2, 32'd3, 1'b0, 32'd4, 33);

        calistir("izolasyon", 1'b0, 5'd8, 32'd6, 32'd8, 1'b1, 32'd100, 65);

        $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

endmodule

// File: doc/carpma_siralayici.md
# carpma_siralayici

Multi-cycle sequencer that executes the core's two multiply-bearing custom operations, KAREAL.TOPLA (a·a + b·b) and CARP.CIKAR (a·b − a), on one shared 32-cycle shift-add multiplier instead of parallel single-cycle multipliers. It sits beside the core's register file. The decoder issues one request with both source operand values and the destination tag. The result goes back to the register-file write port through a valid/ready handshake. One operation is in flight at a time.

## Interface
- `GENISLIK`, default 32: operand, product and result width; also the multiplier step count per product.
- `saat` in, 1: clock; all state changes on the rising edge.
- `reset` in, 1: synchronous, active-low reset.
- `istek_gecerli` in, 1: request valid.
- `istek_hazir` out, 1: request ready; high only in state BOS.
- `islem` in, 1: operation select; 0 = KAREAL.TOPLA, 1 = CARP.CIKAR.
- `rd_adres` in, 5: destination register tag; passed through unchanged.
- `a` in, GENISLIK: rs1 value.
- `b` in, GENISLIK: rs2 value.
- `sonuc_gecerli` out, 1: result valid.
- `sonuc_hazir` in, 1: consumer ready.
- `sonuc` out, GENISLIK: result value.
- `sonuc_rd` out, 5: destination tag of the result.
- `mesgul` out, 1: high in any state other than BOS.

## Operation
- States:
  - BOS: idle.
  - CARP1: product 1.
  - CARP2: product 2; KAREAL.TOPLA only.
  - BIRLESTIR: combine.
  - SONUC: hold result.
- Accept happens when `istek_gecerli` and `istek_hazir` are both high at an edge. At that edge:
  - `a`, `b`, `islem` and `rd_adres` are captured into internal registers.
  - Multiplicand and multiplier are loaded: (a, a) for KAREAL.TOPLA, (a, b) for CARP.CIKAR.
  - The accumulator and step counter are cleared.
  - The state goes to CARP1.
- Inputs changing after the accept edge have no effect.
- Each CARP1/CARP2 step:
  - If multiplier bit 0 is 1, then accumulator += multiplicand.
  - Multiplicand is shifted left by 1 and multiplier is shifted right by 1, both truncated to GENISLIK.
  - The counter increments.
- Each product runs exactly GENISLIK steps. There is no early termination, so latency is data-independent.
- End of CARP1:
  - The product is saved to the intermediate register `ara`.
  - KAREAL.TOPLA: the multiplier pair is reloaded with (b, b), the accumulator is cleared, and the state goes to CARP2.
  - CARP.CIKAR: the state goes to BIRLESTIR.
- End of CARP2: the state goes to BIRLESTIR with the second product in the accumulator.
- BIRLESTIR takes one edge:
  - KAREAL.TOPLA: `sonuc` = ara + accumulator.
  - CARP.CIKAR: `sonuc` = ara − captured a.
  - `sonuc_rd` = captured tag; the state goes to SONUC.
- SONUC:
  - `sonuc_gecerli` = 1.
  - `sonuc` and `sonuc_rd` are held stable until the edge where `sonuc_hazir` = 1, which moves the state to BOS.
  - There is no same-cycle re-accept. `istek_hazir` rises the cycle after the result handshake.
- Arithmetic:
  - All products, sums and differences are modulo 2^GENISLIK (low GENISLIK bits kept).
  - Results are bit-identical for unsigned and two's-complement interpretations.
  - No overflow flag.
- Tag 0 is processed normally. The register file discards writes to x0.
- While busy, `istek_gecerli` is ignored; the requester must hold the request until it sees `istek_hazir`.

## Timing
- Reset (`reset` = 0 at an edge) takes priority over everything, including mid-operation; the operation is aborted. After that edge:
  - State is BOS.
  - `sonuc_gecerli`, `sonuc`, `sonuc_rd`, `mesgul`, `ara`, the accumulator and the counter are all 0.
  - `istek_hazir` = 1 from the first cycle after reset is released.
- Latency, with the accept edge as edge 0, until `sonuc_gecerli` goes high:
  - CARP.CIKAR: after edge GENISLIK+1 = 33.
  - KAREAL.TOPLA: after edge 2·GENISLIK+1 = 65.
- Minimum request-to-request interval (consumer always ready):
  - CARP.CIKAR: 35 cycles.
  - KAREAL.TOPLA: 67 cycles.
- `istek_hazir` and `mesgul` are purely decodes of registered state.
- `sonuc_gecerli` is high exactly in SONUC.

## Test plan
- KAREAL.TOPLA, a=3, b=4, rd=5 -> `sonuc` = 25 and `sonuc_rd` = 5; `sonuc_gecerli` rises 65 edges after accept.
- CARP.CIKAR, a=7, b=5, rd=9 -> `sonuc` = 28 and `sonuc_rd` = 9, 33 edges after accept.
- Wrap-around:
  - KAREAL.TOPLA, a=0x00010000, b=0xFFFFFFFF -> `sonuc` = 0x00000001.
  - CARP.CIKAR, a=0xFFFFFFFF, b=2 -> `sonuc` = 0xFFFFFFFF.
- Backpressure: hold `sonuc_hazir` = 0 for 10 cycles in SONUC while driving a new request ->
  - `sonuc` and `sonuc_rd` stay stable.
  - The new request is not accepted.
  - After the handshake, `istek_hazir` rises the next cycle and the held request is accepted.
- Reset mid-operation: drive `reset` = 0 on the 20th CARP1 cycle ->
  - All outputs are 0 and the state is BOS.
  - After release, CARP.CIKAR with a=2, b=3 -> `sonuc` = 4.
- Input isolation: after accepting KAREAL.TOPLA with a=6, b=8, change `a`, `b` and `islem` every cycle -> `sonuc` = 100.
